// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding used by both transmitter and receiver.
package uart_pkg;

  localparam int unsigned UART_STATE_W = 3;

  localparam logic [UART_STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [UART_STATE_W-1:0] START  = 3'd1;
  localparam logic [UART_STATE_W-1:0] DATA   = 3'd2;
  localparam logic [UART_STATE_W-1:0] PARITY = 3'd3;
  localparam logic [UART_STATE_W-1:0] STOP   = 3'd4;

  typedef enum logic [UART_STATE_W-1:0] {
    StIdle   = IDLE,
    StStart  = START,
    StData   = DATA,
    StParity = PARITY,
    StStop   = STOP
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: bit_end pulses on the tick that completes one bit period.
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic baud_tick,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] CntMax = CntW'(OVERSAMPLE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // clear dominates a coincident tick, so that tick never counts toward the next bit
  assign bit_end = baud_tick & ~clear & (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (baud_tick) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with registered serial output.
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 ready_q;
  logic                 done_q, done_d;
  logic                 handshake;
  logic                 timer_clear;
  logic                 bit_end;
  logic                 last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  function automatic logic out_bit(input logic [DATA_BITS-1:0] s);
    return MSB_FIRST ? s[DATA_BITS-1] : s[0];
  endfunction

  function automatic logic [DATA_BITS-1:0] shifted(input logic [DATA_BITS-1:0] s);
    return MSB_FIRST ? {s[DATA_BITS-2:0], 1'b0} : {1'b0, s[DATA_BITS-1:1]};
  endfunction

  assign handshake   = tx_valid & ready_q;
  // Holding the timer clear through IDLE also discards a tick coincident with the handshake
  assign timer_clear = (state_q == StIdle);
  assign last_stop   = (STOP_BITS == 1) || stop_q;

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .baud_tick(baud_tick),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d  = StStart;
          shift_d  = tx_data;
          idx_d    = '0;
          stop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ PARITY_ODD;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == LastIdx) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shifted(shift_q);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is derived from the next state so tx changes together with the state register
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = out_bit(shift_d);
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      ready_q  <= (state_d == StIdle);
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_ready   = ready_q;
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: two parameterisations against a frame-level model.
module tb_uart_tx_param;

  localparam int A_BITS = 8;
  localparam int A_OVS  = 16;
  localparam int A_STOP = 1;
  localparam bit A_MSB  = 1'b0;
  localparam bit A_ODD  = 1'b0;
  localparam int B_BITS = 5;
  localparam int B_OVS  = 4;
  localparam int B_STOP = 2;
  localparam bit B_MSB  = 1'b1;
  localparam bit B_ODD  = 1'b1;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_a, valid_a, ready_a, tx_a, busy_a, done_a;
  logic [7:0] data_a;
  logic       tick_b, valid_b, ready_b, tx_b, busy_b, done_b;
  logic [4:0] data_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_BITS (A_BITS),
    .OVERSAMPLE(A_OVS),
    .STOP_BITS (A_STOP),
    .MSB_FIRST (A_MSB),
    .PARITY_ODD(A_ODD)
  ) u_dut_a (
    .clk       (clk),
    .rst       (rst_n),
    .baud_tick (tick_a),
    .tx_data   (data_a),
    .tx_valid  (valid_a),
    .tx_ready  (ready_a),
    .tx        (tx_a),
    .busy      (busy_a),
    .frame_done(done_a)
  );

  uart_tx_param #(
    .DATA_BITS (B_BITS),
    .OVERSAMPLE(B_OVS),
    .STOP_BITS (B_STOP),
    .MSB_FIRST (B_MSB),
    .PARITY_ODD(B_ODD)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst_n),
    .baud_tick (tick_b),
    .tx_data   (data_b),
    .tx_valid  (valid_b),
    .tx_ready  (ready_b),
    .tx        (tx_b),
    .busy      (busy_b),
    .frame_done(done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Only the selected instance sees valid/tick; the other is held quiet.
  task automatic drive(input int sel, input logic [8:0] d, input logic v, input logic t);
    if (sel == 0) begin
      data_a = d[7:0]; valid_a = v; tick_a = t; valid_b = 1'b0; tick_b = 1'b0;
    end else begin
      data_b = d[4:0]; valid_b = v; tick_b = t; valid_a = 1'b0; tick_a = 1'b0;
    end
  endtask

  // Expected line levels, one entry per bit period, in transmission order.
  function automatic int build_frame(input int sel, input logic [8:0] d, output logic [15:0] bits);
    int nb, ns, n;
    bit msb, odd, p;
    nb   = (sel == 0) ? A_BITS : B_BITS;
    ns   = (sel == 0) ? A_STOP : B_STOP;
    msb  = (sel == 0) ? A_MSB : B_MSB;
    odd  = (sel == 0) ? A_ODD : B_ODD;
    bits = '1;
    n    = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < nb; i++) begin
      bits[n] = msb ? d[nb-1-i] : d[i];
      n++;
    end
    if (PAR_EN) begin
      p = odd;
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      bits[n] = p;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      bits[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  // Called just after a negedge with the selected instance idle. per > 0: tick on every
  // per-th edge counting the handshake edge as 0; per == 0: random ticks. abort_bit >= 0
  // pulls reset mid-way through that data bit. Returns just after a negedge.
  task automatic run_frame(input int sel, input logic [8:0] d, input int per, input bit keep,
                           input logic [8:0] next_d, input int abort_bit);
    logic [15:0] bits;
    int          nbits, ovs, idx, ticks, k;
    bit          t, done;
    logic        o_tx, o_busy, o_done, o_ready;
    nbits = build_frame(sel, d, bits);
    ovs   = (sel == 0) ? A_OVS : B_OVS;
    check_eq("ready_before_frame", (sel == 0) ? ready_a : ready_b, 1);
    t = (per > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    drive(sel, d, 1'b1, t);
    @(posedge clk);
    idx = 0; ticks = 0; k = 0; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      o_tx    = (sel == 0) ? tx_a : tx_b;
      o_busy  = (sel == 0) ? busy_a : busy_b;
      o_done  = (sel == 0) ? done_a : done_b;
      o_ready = (sel == 0) ? ready_a : ready_b;
      if (idx < nbits) begin
        check_eq($sformatf("tx_bit%0d", idx), o_tx, bits[idx]);
        check_eq("busy_in_frame", o_busy, 1);
        check_eq("frame_done_early", o_done, 0);
        check_eq("ready_in_frame", o_ready, 0);
        if (abort_bit >= 0 && idx == abort_bit + 1 && ticks == ovs / 2) begin
          drive(sel, d, 1'b0, 1'b0);
          #2 rst_n = 1'b0;
          #1;
          check_eq("abort_tx", (sel == 0) ? tx_a : tx_b, 1);
          check_eq("abort_busy", (sel == 0) ? busy_a : busy_b, 0);
          check_eq("abort_ready", (sel == 0) ? ready_a : ready_b, 0);
          check_eq("abort_done", (sel == 0) ? done_a : done_b, 0);
          @(negedge clk);
          check_eq("abort_hold_tx", (sel == 0) ? tx_a : tx_b, 1);
          #2 rst_n = 1'b1;
          @(negedge clk);
          check_eq("abort_release_ready", (sel == 0) ? ready_a : ready_b, 1);
          check_eq("abort_release_busy", (sel == 0) ? busy_a : busy_b, 0);
          check_eq("abort_release_tx", (sel == 0) ? tx_a : tx_b, 1);
          return;
        end
      end else begin
        check_eq("frame_done", o_done, 1);
        check_eq("idle_tx", o_tx, 1);
        check_eq("idle_busy", o_busy, 0);
        check_eq("idle_ready", o_ready, 1);
        if (per > 0) check_eq("frame_len", k, nbits * ovs * per);
        drive(sel, keep ? next_d : d, keep, 1'b0);
        done = 1'b1;
      end
      if (!done) begin
        k++;
        t = (per > 0) ? ((k % per) == 0) : ($urandom_range(0, 2) == 0);
        if (keep) drive(sel, next_d, 1'b1, t);
        else drive(sel, 9'($urandom), ($urandom_range(0, 9) == 0), t);
        if (t) begin
          ticks++;
          if (ticks == ovs) begin
            idx++;
            ticks = 0;
          end
        end
      end
    end
    check_eq("frame_timeout", done, 1);
  endtask

  initial begin
    int sel, per, gap;
    logic [8:0] d;
    data_a = '0; valid_a = 1'b0; tick_a = 1'b0;
    data_b = '0; valid_b = 1'b0; tick_b = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready_a", ready_a, 0);
    check_eq("rst_tx_a", tx_a, 1);
    check_eq("rst_busy_a", busy_a, 0);
    check_eq("rst_done_a", done_a, 0);
    check_eq("rst_ready_b", ready_b, 0);
    check_eq("rst_tx_b", tx_b, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready_a", ready_a, 1);
    check_eq("post_rst_ready_b", ready_b, 1);
    check_eq("post_rst_busy_b", busy_b, 0);

    run_frame(0, 9'h0A5, 1, 1'b0, 9'h000, -1);
    @(negedge clk);
    check_eq("done_pulse_one_clk", done_a, 0);
    run_frame(0, 9'h007, 1, 1'b0, 9'h000, -1);
    run_frame(1, 9'h013, 5, 1'b0, 9'h000, -1);
    run_frame(1, 9'h007, 5, 1'b0, 9'h000, -1);
    run_frame(0, 9'h000, 1, 1'b1, 9'h0FF, -1);
    run_frame(0, 9'h0FF, 1, 1'b0, 9'h000, -1);
    run_frame(0, 9'h05A, 1, 1'b0, 9'h000, 3);
    run_frame(0, 9'h0A5, 1, 1'b0, 9'h000, -1);

    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 1);
      per = $urandom_range(0, 3);
      d   = 9'($urandom);
      run_frame(sel, d, per, 1'b0, 9'h000, -1);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, legal 5..9; payload bits per frame.
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, legal 4..64; baud_tick pulses per bit period.
REQ-003 SHALL provide parameter STOP_BITS, default 1, legal 1 or 2; stop bits per frame.
REQ-004 SHALL provide parameter MSB_FIRST, default 0; 0 = LSB sent first, 1 = MSB sent first.
REQ-005 SHALL provide parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; used only with UART_TX_PARITY_EN.
REQ-006 SHALL have port clk, input, 1; sole clock, all state on the rising edge.
REQ-007 SHALL have port rst, input, 1; asynchronous active-low reset.
REQ-008 SHALL have port baud_tick, input, 1; one-clk pulse at OVERSAMPLE x baud rate.
REQ-009 SHALL have port tx_data, input, DATA_BITS; payload, sampled on handshake.
REQ-010 SHALL have port tx_valid, input, 1; payload offered.
REQ-011 SHALL have port tx_ready, output, 1; block can accept a payload.
REQ-012 SHALL have port tx, output, 1; serial line, idle high.
REQ-013 SHALL have port busy, output, 1; frame in progress.
REQ-014 SHALL have port frame_done, output, 1; one-clk pulse at end of last stop bit.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL assert tx_ready iff state is IDLE; handshake = tx_valid & tx_ready in the same clk.
REQ-017 SHALL latch tx_data into an internal shift register on handshake and enter START next clk; tx_data is ignored at all other times.
REQ-018 SHALL drive tx registered (glitch-free): 1 in IDLE, 0 in START, current payload bit in DATA, parity bit in PARITY, 1 in STOP.
REQ-019 SHALL hold each bit for exactly OVERSAMPLE baud_tick pulses; the tick counter clears on entering START and wraps at OVERSAMPLE-1, the wrap tick being the bit boundary.
REQ-020 SHALL, at each DATA bit boundary, advance to the next bit; after bit DATA_BITS-1 go to PARITY (if compiled in) else STOP.
REQ-021 SHALL stay in STOP for STOP_BITS bit periods, then enter IDLE and pulse frame_done for one clk in that same transition.
REQ-022 SHALL assert busy in every state except IDLE.
REQ-023 SHALL advance no counter while baud_tick is low; a baud_tick held high for N clks counts as N ticks.
REQ-024 SHALL ignore tx_valid while busy; a tx_valid held through frame end is accepted on the first IDLE clk (minimum 1 clk idle-high between frames).
REQ-025 SHALL treat a handshake and a baud_tick in the same clk as handshake only; that tick is not counted toward the start bit.

Reset
REQ-026 SHALL, on rst low, asynchronously force state IDLE, tx=1, tx_ready=1 only after release (0 while rst low), busy=0, frame_done=0, all counters and shift register 0.
REQ-027 SHALL abort any frame in progress on reset; no partial frame resumes after release.

Configuration
REQ-028 SHALL, with macro UART_TX_PARITY_EN defined, insert one PARITY bit period between DATA and STOP, value = XOR of payload bits XOR PARITY_ODD.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit PARITY state and logic entirely; frame = 1 + DATA_BITS + STOP_BITS bit periods.

Structure
REQ-030 SHALL place state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit) in shared package uart_pkg, reused by the receiver.
REQ-031 SHALL factor the oversample tick counter into sub-module uart_bit_timer (ports clk, rst, clear, baud_tick, bit_end).

Verification
REQ-032 SHALL cover: defaults, tx_data=8'hA5 handshake, baud_tick every clk -> tx = 0 for 16 clks, then 1,0,1,0,0,1,0,1 for 16 clks each, then 1 for 16 clks, frame_done at clk 161 after handshake.
REQ-033 SHALL cover: UART_TX_PARITY_EN, PARITY_ODD=0, tx_data=8'h07 -> parity bit 1; PARITY_ODD=1 -> 0; frame 11 bit periods.
REQ-034 SHALL cover: DATA_BITS=5, MSB_FIRST=1, STOP_BITS=2, tx_data=5'b10011 -> bits 1,0,0,1,1, then 2 stop periods high.
REQ-035 SHALL cover: tx_valid held high with two payloads 8'h00, 8'hFF -> second accepted exactly 1 clk after first frame_done; tx_valid pulses while busy -> no effect.
REQ-036 SHALL cover: rst low mid-DATA bit 3 -> tx=1, busy=0 immediately (asynchronous); after release new frame starts cleanly on next handshake.
REQ-037 SHALL cover: baud_tick every 5th clk, OVERSAMPLE=4 -> each bit lasts 20 clks; handshake coincident with baud_tick -> start bit still 4 ticks long.
